// File: rtl/bsg_lru_pseudo_tree_tracker.sv
// rtl/bsg_lru_pseudo_tree_tracker.sv - per-set pseudo-LRU tree tracker with registered victim output
//
// Keeps one heap-ordered tree of ways_p-1 bits per set. Touches point the tree
// away from the touched way, clears zero a set's tree, and victim queries are
// answered one cycle later through a one-entry valid/ready output register.
//
// Ports:
//   clk_i, reset_n_i     clock, asynchronous active-low reset
//   touch_v_i            touch request; touch_set_i/touch_way_i select set and MRU way
//   clear_v_i            zero the tree of touch_set_i (wins over touch_v_i)
//   v_i, set_i, ready_o  victim query handshake
//   v_o, way_id_o, lru_o registered result: LRU way and tree snapshot
//   yumi_i               consumer takes the result
module bsg_lru_pseudo_tree_tracker #(
    parameter int ways_p = 8,
    parameter int sets_p = 4,
    localparam int lg_ways_lp = $clog2(ways_p),
    localparam int lg_sets_lp = (sets_p > 1) ? $clog2(sets_p) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  touch_v_i,
    input  logic [lg_sets_lp-1:0] touch_set_i,
    input  logic [lg_ways_lp-1:0] touch_way_i,
    input  logic                  clear_v_i,
    input  logic                  v_i,
    input  logic [lg_sets_lp-1:0] set_i,
    output logic                  ready_o,
    output logic                  v_o,
    output logic [lg_ways_lp-1:0] way_id_o,
    output logic [ways_p-2:0]     lru_o,
    input  logic                  yumi_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e state_r, state_n;

    logic [ways_p-2:0]     tree_r [sets_p];
    logic [lg_sets_lp-1:0] touch_idx, query_idx;
    logic                  upd_v;
    logic [ways_p-2:0]     upd_tree;
    logic [ways_p-2:0]     query_tree;
    logic                  accept;

    // Node (2^k - 1 + j) lies on level k; it is on the path to way w exactly
    // when the top k bits of w equal j. Iterating over all nodes keeps every
    // index a loop constant.
    function automatic logic [ways_p-2:0] touch_f(input logic [ways_p-2:0] t,
                                                  input logic [lg_ways_lp-1:0] w);
        logic [ways_p-2:0] r;
        r = t;
        for (int k = 0; k < lg_ways_lp; k++) begin
            for (int j = 0; j < (1 << k); j++) begin
                if (int'(w >> (lg_ways_lp - k)) == j) begin
                    r[(1 << k) - 1 + j] = ~w[lg_ways_lp-1-k];
                end
            end
        end
        return r;
    endfunction

    // Walk from the root: each id bit is the bit of the node chosen by the
    // id bits already resolved above it.
    function automatic logic [lg_ways_lp-1:0] encode_f(input logic [ways_p-2:0] t);
        logic [lg_ways_lp-1:0] w;
        w = '0;
        for (int k = 0; k < lg_ways_lp; k++) begin
            for (int j = 0; j < (1 << k); j++) begin
                if (int'(w >> (lg_ways_lp - k)) == j) begin
                    w[lg_ways_lp-1-k] = t[(1 << k) - 1 + j];
                end
            end
        end
        return w;
    endfunction

    // A single set has no index; force slot 0 regardless of the set inputs.
    assign touch_idx = (sets_p == 1) ? '0 : touch_set_i;
    assign query_idx = (sets_p == 1) ? '0 : set_i;

    assign upd_v    = touch_v_i | clear_v_i;
    assign upd_tree = clear_v_i ? '0 : touch_f(tree_r[touch_idx], touch_way_i);

    // Write-first: a same-cycle update to the queried set is forwarded.
    assign query_tree = (upd_v && (touch_idx == query_idx)) ? upd_tree : tree_r[query_idx];

    assign v_o     = (state_r == FULL);
    assign ready_o = ~v_o | yumi_i;
    assign accept  = v_i & ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < sets_p; s++) begin
                tree_r[s] <= '0;
            end
        end else if (upd_v) begin
            for (int s = 0; s < sets_p; s++) begin
                if (touch_idx == lg_sets_lp'(s)) begin
                    tree_r[s] <= upd_tree;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= EMPTY;
            way_id_o <= '0;
            lru_o    <= '0;
        end else begin
            state_r <= state_n;
            if (accept) begin
                way_id_o <= encode_f(query_tree);
                lru_o    <= query_tree;
            end
        end
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            EMPTY:   if (v_i) state_n = FULL;
            FULL:    if (yumi_i) state_n = v_i ? FULL : EMPTY;
            default: state_n = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_bsg_lru_pseudo_tree_tracker.sv
// tb/tb_bsg_lru_pseudo_tree_tracker.sv - directed vector bench for bsg_lru_pseudo_tree_tracker
module tb_bsg_lru_pseudo_tree_tracker;

    logic       clk;
    logic       reset_n;
    logic       touch_v;
    logic [1:0] touch_set;
    logic [2:0] touch_way;
    logic       clear_v;
    logic       v_in;
    logic [1:0] set_in;
    logic       ready;
    logic       v_out;
    logic [2:0] way_id;
    logic [6:0] lru;
    logic       yumi;

    int checks = 0;
    int passed = 0;

    bsg_lru_pseudo_tree_tracker #(.ways_p(8), .sets_p(4)) dut (
        .clk_i       (clk),
        .reset_n_i   (reset_n),
        .touch_v_i   (touch_v),
        .touch_set_i (touch_set),
        .touch_way_i (touch_way),
        .clear_v_i   (clear_v),
        .v_i         (v_in),
        .set_i       (set_in),
        .ready_o     (ready),
        .v_o         (v_out),
        .way_id_o    (way_id),
        .lru_o       (lru),
        .yumi_i      (yumi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       tv;
        logic [1:0] ts;
        logic [2:0] tw;
        logic       cv;
        logic       qv;
        logic [1:0] qs;
        logic       y;
        logic       e_v;
        logic [2:0] e_way;
        logic [6:0] e_lru;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(logic tv, logic [1:0] ts, logic [2:0] tw, logic cv,
                                logic qv, logic [1:0] qs, logic y,
                                logic e_v, logic [2:0] e_way, logic [6:0] e_lru);
        vec_t r;
        r.tv = tv; r.ts = ts; r.tw = tw; r.cv = cv;
        r.qv = qv; r.qs = qs; r.y = y;
        r.e_v = e_v; r.e_way = e_way; r.e_lru = e_lru;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input vec_t x);
        touch_v = x.tv; touch_set = x.ts; touch_way = x.tw; clear_v = x.cv;
        v_in = x.qv; set_in = x.qs; yumi = x.y;
    endtask

    task automatic step_check(input string name, input vec_t x);
        @(negedge clk);
        drive(x);
        @(posedge clk);
        #1;
        check({name, ".v_o"}, 32'(v_out), 32'(x.e_v));
        if (x.e_v) begin
            check({name, ".way_id"}, 32'(way_id), 32'(x.e_way));
            check({name, ".lru"}, 32'(lru), 32'(x.e_lru));
        end
    endtask

    initial begin
        // Table: one row per cycle; expectations are the outputs after that edge.
        vecs[0]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 7'b0000000);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000);
        vecs[2]  = mk(0, 0, 0, 0, 1, 0, 0, 1, 4, 7'b0001011);
        vecs[3]  = mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 7'b0000000);
        for (int i = 1; i < 8; i++) vecs[3+i] = mk(1, 1, 3'(i), 0, 0, 0, 0, 0, 0, 7'b0000000);
        vecs[11] = mk(0, 0, 0, 0, 1, 1, 0, 1, 0, 7'b0000000);
        vecs[12] = mk(0, 0, 0, 0, 1, 2, 1, 1, 0, 7'b0000000);
        vecs[13] = mk(1, 2, 0, 0, 1, 2, 1, 1, 4, 7'b0001011);
        vecs[14] = mk(1, 2, 3, 1, 0, 0, 1, 0, 0, 7'b0000000);
        vecs[15] = mk(0, 0, 0, 0, 1, 2, 0, 1, 0, 7'b0000000);
        vecs[16] = mk(1, 3, 2, 0, 1, 3, 1, 1, 4, 7'b0010001);
        vecs[17] = mk(1, 3, 0, 0, 1, 3, 1, 1, 4, 7'b0011011);
        vecs[18] = mk(1, 3, 4, 0, 1, 3, 1, 1, 3, 7'b0111110);
        vecs[19] = mk(1, 0, 7, 0, 1, 1, 1, 1, 0, 7'b0000000);
        vecs[20] = mk(0, 0, 0, 0, 1, 0, 1, 1, 2, 7'b0001010);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000);

        reset_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0));
        repeat (2) @(posedge clk);
        #1;
        check("reset.v_o", 32'(v_out), 0);
        check("reset.ready", 32'(ready), 1);
        check("reset.way_id", 32'(way_id), 0);
        check("reset.lru", 32'(lru), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 22; i++) step_check($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: load a result, then stall while touching the same set.
        step_check("bp_load", mk(0, 0, 0, 0, 1, 0, 0, 1, 2, 7'b0001010));
        @(negedge clk);
        drive(mk(1, 0, 2, 0, 1, 0, 0, 0, 0, 7'b0));
        #1;
        check("bp.ready_stall", 32'(ready), 0);
        @(posedge clk);
        #1;
        check("bp.v_hold", 32'(v_out), 1);
        check("bp.way_hold", 32'(way_id), 2);
        check("bp.lru_hold", 32'(lru), 32'(7'b0001010));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 7'b0));
        #1;
        check("bp.ready_yumi", 32'(ready), 1);
        @(posedge clk);
        #1;
        check("bp.v_next", 32'(v_out), 1);
        check("bp.way_next", 32'(way_id), 4);
        check("bp.lru_next", 32'(lru), 32'(7'b0011001));
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0));
        @(posedge clk);
        #1;
        check("ar.v_before", 32'(v_out), 1);

        // Asynchronous reset between edges while a result is pending.
        #2;
        reset_n = 1'b0;
        #1;
        check("ar.v_o", 32'(v_out), 0);
        check("ar.ready", 32'(ready), 1);
        check("ar.way_id", 32'(way_id), 0);
        check("ar.lru", 32'(lru), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step_check("ar.q0", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 7'b0000000));
        step_check("ar.q3", mk(0, 0, 0, 0, 1, 3, 1, 1, 0, 7'b0000000));
        step_check("ar.q1", mk(0, 0, 0, 0, 1, 1, 1, 1, 0, 7'b0000000));
        step_check("ar.drain", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0000000));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
